coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage directly upstream of the vending machine controller.
- Debounces four raw coin-sensor lines and queues detected coins in a small FIFO.
- Generates the controller's Enable and single-cycle coin pulses (OneDollar/FiftyCents/TenCents/FiveCents).
- Tracks the session total so no coin pulse lands in the cycle the controller delivers, where it would be lost.

Parameters:
PRICE, 125, session threshold in cents; must equal the controller's Price.
DEBOUNCE_CYCLES, 4, consecutive samples a sensor must hold a level to register it (>=2).
GAP_CYCLES, 1, idle cycles between successive coin pulses (>=1).
FIFO_DEPTH, 4, coin queue entries (power of 2).

Ports:
CLK  in  1  system clock, all logic on rising edge.
RST  in  1  synchronous, active-high reset.
CoinSense  in  4  raw sensors: [3]=$1.00, [2]=$0.50, [1]=$0.10, [0]=$0.05.
Deliver  in  1  controller's Deliver; high one cycle when a sale completes.
Enable  out  1  one-cycle wake pulse to controller.
OneDollar  out  1  one-cycle coin pulse, 100c.
FiftyCents  out  1  one-cycle coin pulse, 50c.
TenCents  out  1  one-cycle coin pulse, 10c.
FiveCents  out  1  one-cycle coin pulse, 5c.
Reject  out  1  one-cycle pulse: detected coin dropped, FIFO full.
Total  out  8  cents issued in the current session.

Behaviour:
- Reset (RST high at an edge): all outputs 0, FIFO empty, debounce counters and pending flags cleared, FSM=IDLE, Total=0. Reset overrides every other event, including mid-pulse and mid-session.
- Debounce, per channel:
  - Counter counts consecutive high samples. On the DEBOUNCE_CYCLES-th consecutive high sample, set the channel's pending flag.
  - The channel re-arms only after DEBOUNCE_CYCLES consecutive low samples.
  - A shorter high burst produces nothing.
- Enqueue:
  - At most one pending channel enters the FIFO per cycle, in priority order $1 > 50c > 10c > 5c. Lower-priority flags stay pending.
  - FIFO write takes effect at the edge the flag is seen, so the FIFO is non-empty the following cycle.
  - If the FIFO is full when a flag would be written: Reject=1 for one cycle, flag cleared, coin discarded.
  - An enqueue and a pop in the same cycle are both allowed; occupancy is unchanged.
- FSM, registered outputs:
  - IDLE: if FIFO non-empty, go to WAKE.
  - WAKE: Enable=1 for exactly one cycle, then go to ISSUE.
  - ISSUE: pop FIFO head and drive exactly one coin output high for one cycle; Total += value.
    - If new Total >= PRICE, go to HOLD.
    - Otherwise go to GAP.
  - GAP: hold all coin outputs 0 for GAP_CYCLES cycles, then go to ISSUE if FIFO non-empty, else WAIT.
  - WAIT: go to ISSUE when FIFO becomes non-empty.
  - HOLD: no coin pulses, FIFO keeps accepting coins. On Deliver=1: Total<=0, go to IDLE. Remaining queued coins start a new session (Enable again).
  - Deliver in any state other than HOLD is ignored.
- Arithmetic: Total is 8-bit unsigned. Max reachable value is (PRICE-5)+100 = 220 at default, so no wrap. Implementation asserts PRICE+95 <= 255.
- At most one of Enable / coin outputs is high in any cycle.

Test Plan:
1. Defaults; CoinSense[3] high 6 cycles from cycle 0 -> flag at edge 3 (4th sample); Enable=1 at cycle 5; OneDollar=1 at cycle 6 only; Total=100 after; FSM=WAIT.
2. CoinSense[1] high 3 cycles, then low -> no pulses, no Enable, Total stays 0.
3. Insert $1 then 50c -> Enable, OneDollar, one gap cycle, FiftyCents; Total=150, HOLD. Then insert 10c -> no TenCents while Deliver=0. Deliver pulse -> Total=0, next cycle IDLE, then Enable, TenCents, Total=10.
4. CoinSense[3] and CoinSense[1] rise in the same cycle -> dollar enqueued one cycle before ten; output order OneDollar, gap, TenCents; Total=110.
5. Hold FSM in HOLD (Total=125). Debounce five separate 5c coins -> first four queued; fifth gives Reject=1 for one cycle; after Deliver exactly four FiveCents pulses across the new session, Total=20.
6. RST=1 during the ISSUE cycle of a $1 pulse -> next edge: all outputs 0, Total=0, FIFO empty. After RST drops, no pulses occur without new sensor input.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces four coin sensors, queues detected coins
// in a small FIFO and replays them to the vending controller as an Enable
// wake pulse followed by single-cycle coin pulses, holding off once the
// session total reaches the price until the controller delivers.
module coin_acceptor #(
   parameter int PRICE           = 125,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 1,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] CoinSense,
   input  logic       Deliver,
   output logic       Enable,
   output logic       OneDollar,
   output logic       FiftyCents,
   output logic       TenCents,
   output logic       FiveCents,
   output logic       Reject,
   output logic [7:0] Total
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [7:0]    PRICE_V  = 8'(PRICE);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAKE  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_HOLD  = 3'd5;

   // Elaboration-time guards on parameter ranges the arithmetic relies on.
   if (PRICE + 95 > 255) begin : g_price_check
      $error("coin_acceptor: PRICE+95 must not exceed 255");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_deb_check
      $error("coin_acceptor: DEBOUNCE_CYCLES must be at least 2");
   end
   if (GAP_CYCLES < 1) begin : g_gap_check
      $error("coin_acceptor: GAP_CYCLES must be at least 1");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("coin_acceptor: FIFO_DEPTH must be a power of 2, at least 2");
   end

   logic [3:0]    detect;
   logic [3:0]    pending_reg;
   logic [3:0]    pending_clr;
   logic [1:0]    sel_code;
   logic          have_pending;
   logic          do_write;
   logic          do_reject;
   logic          reject_reg;

   logic [1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          fifo_empty;
   logic          fifo_full;
   logic [1:0]    head_code;
   logic          pop;

   logic [2:0]    state_reg;
   logic [GW-1:0] gap_cnt_reg;
   logic          gap_done;
   logic [7:0]    total_reg;
   logic          enable_reg;
   logic [3:0]    coin_reg;

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_deb
      logic [CW-1:0] cnt_reg;
      logic          latched_reg;
      // Count consecutive samples that differ from the accepted level; flip after a full run.
      always_ff @(posedge CLK) begin
         if (RST) begin
            cnt_reg     <= '0;
            latched_reg <= 1'b0;
         end else if (CoinSense[gi] != latched_reg) begin
            if (cnt_reg == DEB_LAST) begin
               cnt_reg     <= '0;
               latched_reg <= CoinSense[gi];
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end else begin
            cnt_reg <= '0;
         end
      end
      // A coin is detected on the sample that completes a high run from the low level.
      assign detect[gi] = CoinSense[gi] && !latched_reg && (cnt_reg == DEB_LAST);
   end

   // Pick the highest-value pending coin; its flag is consumed whether queued or rejected.
   always_comb begin
      sel_code    = 2'd0;
      pending_clr = 4'b0000;
      if (pending_reg[3]) begin
         sel_code    = 2'd3;
         pending_clr = 4'b1000;
      end else if (pending_reg[2]) begin
         sel_code    = 2'd2;
         pending_clr = 4'b0100;
      end else if (pending_reg[1]) begin
         sel_code    = 2'd1;
         pending_clr = 4'b0010;
      end else if (pending_reg[0]) begin
         sel_code    = 2'd0;
         pending_clr = 4'b0001;
      end
   end

   assign have_pending = |pending_reg;
   assign fifo_empty   = (count_reg == '0);
   assign fifo_full    = (count_reg == DEPTH_V);
   assign head_code    = mem[rd_ptr_reg];
   assign gap_done     = (gap_cnt_reg == GAP_LAST);
   assign pop          = !fifo_empty && ((state_reg == S_WAKE) || (state_reg == S_WAIT) ||
                                         ((state_reg == S_GAP) && gap_done));
   // A simultaneous pop frees the slot, so a full queue only rejects when nothing leaves.
   assign do_write     = have_pending && (!fifo_full || pop);
   assign do_reject    = have_pending && fifo_full && !pop;

   // Pending flags, FIFO pointers/occupancy and the Reject pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pending_reg <= 4'b0000;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         reject_reg  <= 1'b0;
      end else begin
         pending_reg <= (pending_reg & ~pending_clr) | detect;
         reject_reg  <= do_reject;
         if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (do_write && !pop)      count_reg <= count_reg + 1'b1;
         else if (pop && !do_write) count_reg <= count_reg - 1'b1;
      end
   end

   // Queue storage; contents are qualified by the pointers so no reset is needed.
   always_ff @(posedge CLK) begin
      if (do_write) mem[wr_ptr_reg] <= sel_code;
   end

   function automatic logic [7:0] coin_value(input logic [1:0] code);
      case (code)
         2'd3:    coin_value = 8'd100;
         2'd2:    coin_value = 8'd50;
         2'd1:    coin_value = 8'd10;
         default: coin_value = 8'd5;
      endcase
   endfunction

   // Session FSM with registered Enable/coin pulses; popping happens on entry to ISSUE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg   <= S_IDLE;
         gap_cnt_reg <= '0;
         total_reg   <= 8'd0;
         enable_reg  <= 1'b0;
         coin_reg    <= 4'b0000;
      end else begin
         enable_reg <= 1'b0;
         coin_reg   <= 4'b0000;
         if (pop) begin
            coin_reg  <= 4'b0001 << head_code;
            total_reg <= total_reg + coin_value(head_code);
         end
         case (state_reg)
            S_IDLE: begin
               if (!fifo_empty) begin
                  state_reg  <= S_WAKE;
                  enable_reg <= 1'b1;
               end
            end
            S_WAKE:  state_reg <= pop ? S_ISSUE : S_WAIT;
            S_ISSUE: begin
               gap_cnt_reg <= '0;
               state_reg   <= (total_reg >= PRICE_V) ? S_HOLD : S_GAP;
            end
            S_GAP: begin
               if (gap_done) state_reg <= pop ? S_ISSUE : S_WAIT;
               else          gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
            S_WAIT: begin
               if (pop) state_reg <= S_ISSUE;
            end
            S_HOLD: begin
               if (Deliver) begin
                  total_reg <= 8'd0;
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign Enable     = enable_reg;
   assign OneDollar  = coin_reg[3];
   assign FiftyCents = coin_reg[2];
   assign TenCents   = coin_reg[1];
   assign FiveCents  = coin_reg[0];
   assign Reject     = reject_reg;
   assign Total      = total_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus pushes expected pulses
// (pulse pattern, Total during the pulse, optional exact cycle) into a queue;
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_coin_acceptor;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] CoinSense = 4'b0000;
   logic       Deliver = 1'b0;
   logic       Enable, OneDollar, FiftyCents, TenCents, FiveCents, Reject;
   logic [7:0] Total;

   coin_acceptor dut (
      .CLK(CLK), .RST(RST), .CoinSense(CoinSense), .Deliver(Deliver),
      .Enable(Enable), .OneDollar(OneDollar), .FiftyCents(FiftyCents),
      .TenCents(TenCents), .FiveCents(FiveCents), .Reject(Reject), .Total(Total)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Pulse pattern order: {Reject, Enable, OneDollar, FiftyCents, TenCents, FiveCents}
   localparam logic [5:0] EV_REJ = 6'b100000;
   localparam logic [5:0] EV_EN  = 6'b010000;
   localparam logic [5:0] EV_D   = 6'b001000;
   localparam logic [5:0] EV_H   = 6'b000100;
   localparam logic [5:0] EV_T   = 6'b000010;
   localparam logic [5:0] EV_F   = 6'b000001;

   typedef struct {
      logic [5:0] ev;
      logic [7:0] total;
      int         at;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   // Monitor: every cycle with a pulse is one transaction checked against the queue head.
   always @(negedge CLK) begin
      logic [5:0] obs;
      exp_t e;
      obs = {Reject, Enable, OneDollar, FiftyCents, TenCents, FiveCents};
      if (obs != 6'b0) begin
         $display("TXN cyc=%0d pulses=%b total=%0d", cyc, obs, Total);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, obs);
         end else begin
            e = sb.pop_front();
            if (obs != e.ev) begin
               errors++;
               $display("FAIL pulse cyc=%0d got=%b required=%b", cyc, obs, e.ev);
            end
            checks++;
            if (Total != e.total) begin
               errors++;
               $display("FAIL pulse_total cyc=%0d got=%0d required=%0d", cyc, Total, e.total);
            end
            if (e.at >= 0) begin
               checks++;
               if (cyc != e.at) begin
                  errors++;
                  $display("FAIL pulse_cycle pulses=%b got=%0d required=%0d", obs, cyc, e.at);
               end
            end
         end
      end
   end

   task automatic push(input logic [5:0] ev, input logic [7:0] tot, input int at);
      exp_t e;
      e.ev = ev;
      e.total = tot;
      e.at = at;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic check_quiet(input string name);
      checks++;
      if ({Reject, Enable, OneDollar, FiftyCents, TenCents, FiveCents} != 6'b0 || Total != 8'd0) begin
         errors++;
         $display("FAIL %s got pulses=%b total=%0d required pulses=000000 total=0", name,
                  {Reject, Enable, OneDollar, FiftyCents, TenCents, FiveCents}, Total);
      end
   endtask

   task automatic check_total(input string name, input logic [7:0] exp_tot);
      checks++;
      if (Total != exp_tot) begin
         errors++;
         $display("FAIL %s total got=%0d required=%0d", name, Total, exp_tot);
      end
      $display("TXN %s total=%0d", name, Total);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      CoinSense = 4'b0000;
      Deliver = 1'b0;
      tick(2);
      check_quiet("reset_state");
      RST = 1'b0;
   endtask

   // One clean coin: high for hi samples, then low long enough to re-arm.
   task automatic insert(input int ch, input int hi);
      CoinSense[ch] = 1'b1;
      tick(hi);
      CoinSense[ch] = 1'b0;
      tick(6);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s missing_pulses got=%0d_outstanding required=0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic pulse_deliver();
      Deliver = 1'b1;
      tick(1);
      Deliver = 1'b0;
   endtask

   initial begin
      int c;

      // 1: single dollar with exact latency, then a 50c lands from WAIT without a new Enable
      do_reset();
      c = cyc;
      push(EV_EN, 8'd0, c + 6);
      push(EV_D, 8'd100, c + 7);
      CoinSense[3] = 1'b1;
      tick(6);
      CoinSense[3] = 1'b0;
      tick(6);
      drain("t1_dollar", 40);
      check_total("t1_total", 8'd100);
      push(EV_H, 8'd150, -1);
      insert(2, 6);
      drain("t1_wait_fifty", 40);

      // 2: short burst is filtered
      do_reset();
      insert(1, 3);
      tick(20);
      drain("t2_glitch", 1);
      check_total("t2_total", 8'd0);

      // 3: session reaches price, later coin held until Deliver starts a new session
      do_reset();
      push(EV_EN, 8'd0, -1);
      push(EV_D, 8'd100, -1);
      push(EV_H, 8'd150, -1);
      insert(3, 6);
      insert(2, 6);
      drain("t3_session", 60);
      check_total("t3_hold_total", 8'd150);
      insert(1, 6);
      tick(20);
      check_total("t3_held_total", 8'd150);
      push(EV_EN, 8'd0, -1);
      push(EV_T, 8'd10, -1);
      pulse_deliver();
      check_total("t3_deliver_clear", 8'd0);
      drain("t3_new_session", 40);
      check_total("t3_final", 8'd10);

      // 4: simultaneous dollar and ten, priority order and one gap cycle
      do_reset();
      c = cyc;
      push(EV_EN, 8'd0, c + 6);
      push(EV_D, 8'd100, c + 7);
      push(EV_T, 8'd110, c + 9);
      CoinSense = 4'b1010;
      tick(6);
      CoinSense = 4'b0000;
      tick(6);
      drain("t4_priority", 40);
      check_total("t4_total", 8'd110);

      // 5: reach exactly PRICE, fill the FIFO in HOLD, fifth coin rejected
      do_reset();
      push(EV_EN, 8'd0, -1);
      push(EV_D, 8'd100, -1);
      push(EV_T, 8'd110, -1);
      push(EV_T, 8'd120, -1);
      push(EV_F, 8'd125, -1);
      insert(3, 6);
      insert(1, 6);
      insert(1, 6);
      insert(0, 6);
      drain("t5_to_price", 60);
      check_total("t5_hold_total", 8'd125);
      push(EV_REJ, 8'd125, -1);
      for (int k = 0; k < 5; k++) insert(0, 6);
      drain("t5_reject", 20);
      push(EV_EN, 8'd0, -1);
      push(EV_F, 8'd5, -1);
      push(EV_F, 8'd10, -1);
      push(EV_F, 8'd15, -1);
      push(EV_F, 8'd20, -1);
      pulse_deliver();
      drain("t5_replay", 60);
      check_total("t5_final", 8'd20);

      // 6: reset during the dollar pulse clears everything and nothing follows
      do_reset();
      c = cyc;
      push(EV_EN, 8'd0, c + 6);
      push(EV_D, 8'd100, c + 7);
      CoinSense[3] = 1'b1;
      tick(6);
      CoinSense[3] = 1'b0;
      tick(1);
      RST = 1'b1;
      tick(1);
      check_quiet("t6_reset_mid_issue");
      RST = 1'b0;
      drain("t6_before_reset", 2);
      tick(30);
      check_total("t6_after_reset", 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
